button_scanner: RTL and testbench

//  Parametrised successor to the display-board button reader. Scans an NBITS

---
 rtl/button_scanner_pkg.sv | 41 ++++
 rtl/scan_debounce.sv | 49 ++++
 rtl/button_scanner.sv | 111 +++++++++++
 tb/tb_button_scanner.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_scanner_pkg
// Purpose  : Scan-state encoding and display-board button layout shared by
//            the button scanner and its users.
// Revision : 1.0 - initial release
// ============================================================================
package button_scanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_UPDATE   = 3'd4
    } scan_state_t;

    // Bit order as it appears on a 16-input display board chain.
    typedef struct packed {
        logic button_b;
        logic button_a;
        logic button_start;
        logic button_select;
        logic dpad_up;
        logic dpad_down;
        logic dpad_left;
        logic dpad_right;
        logic encoder_push;
        logic encoder_a;
        logic encoder_b;
        logic tilt_switch;
        logic door_open;
        logic service_key;
        logic coin_insert;
        logic temperature_alarm;
    } board_buttons_t;

    localparam int c_BOARD_NBITS = $bits(board_buttons_t);

endpackage
`default_nettype wire

// File: rtl/scan_debounce.sv
`default_nettype none
// ============================================================================
// Module   : scan_debounce
// Purpose  : One-bit debouncer counting whole scans; emits press/release pulses.
// Revision : 1.0 - initial release
// ============================================================================
module scan_debounce #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_update,
    input  logic i_sample,
    output logic o_state,
    output logic o_pressed,
    output logic o_released
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_SCANS - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_differs;
    logic               w_flip;

    assign w_differs = (i_sample != o_state);
    assign w_flip    = i_update && w_differs && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            o_state    <= 1'b0;
            o_pressed  <= 1'b0;
            o_released <= 1'b0;
        end else begin
            o_pressed  <= w_flip && !o_state;
            o_released <= w_flip && o_state;
            if (w_flip) begin
                o_state <= ~o_state;
                r_cnt   <= '0;
            end else if (i_update) begin
                // Any scan that agrees with the current state restarts the count.
                r_cnt <= w_differs ? r_cnt + 1'b1 : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_scanner.sv
`default_nettype none
// ============================================================================
// Module   : button_scanner
// Purpose  : Continuously scans a 74HC165-style chain, debounces every input
//            and reports one-cycle press/release events.
// Revision : 1.0 - initial release
// ============================================================================
module button_scanner
    import button_scanner_pkg::*;
#(
    parameter int NBITS          = 16,
    parameter int CLK_DIV        = 16,
    parameter int DEBOUNCE_SCANS = 4,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             shiftreg_clk,
    output logic             shiftreg_loadn,
    input  logic             shiftreg_out,
    output logic [NBITS-1:0] buttons,
    output logic [NBITS-1:0] pressed,
    output logic [NBITS-1:0] released,
    output logic             scan_done
);

    localparam int                 c_DIV_W    = $clog2(CLK_DIV);
    localparam int                 c_BIT_W    = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(NBITS - 1);

    scan_state_t        r_state;
    scan_state_t        w_state_next;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [NBITS-1:0]   r_sample;
    logic               w_phase_end;
    logic               w_update;
    logic               w_sample_now;

    assign w_phase_end  = (r_div_cnt == c_DIV_LAST);
    assign w_update     = (r_state == ST_UPDATE);
    assign w_sample_now = (r_state == ST_SHIFT_LO) && w_phase_end;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (en) w_state_next = ST_LOAD;
            ST_LOAD:     if (w_phase_end) w_state_next = ST_SHIFT_LO;
            ST_SHIFT_LO: if (w_phase_end)
                             w_state_next = (r_bit_cnt == c_BIT_LAST) ? ST_UPDATE : ST_SHIFT_HI;
            ST_SHIFT_HI: if (w_phase_end) w_state_next = ST_SHIFT_LO;
            ST_UPDATE:   w_state_next = en ? ST_LOAD : ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // Pin outputs are decoded from the next state so they stay glitch-free
    // yet line up exactly with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_div_cnt      <= '0;
            r_bit_cnt      <= '0;
            r_sample       <= '0;
            shiftreg_clk   <= 1'b0;
            shiftreg_loadn <= 1'b1;
            scan_done      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            shiftreg_loadn <= (w_state_next != ST_LOAD);
            shiftreg_clk   <= (w_state_next == ST_SHIFT_HI);
            scan_done      <= w_update;

            if ((r_state inside {ST_LOAD, ST_SHIFT_LO, ST_SHIFT_HI}) && !w_phase_end)
                r_div_cnt <= r_div_cnt + 1'b1;
            else
                r_div_cnt <= '0;

            if (r_state == ST_LOAD)
                r_bit_cnt <= '0;
            else if (w_sample_now)
                r_bit_cnt <= r_bit_cnt + 1'b1;

            // First serial bit lands in the MSB.
            if (w_sample_now) begin
                for (int i = 0; i < NBITS; i++) begin
                    if (r_bit_cnt == c_BIT_W'(NBITS - 1 - i))
                        r_sample[i] <= shiftreg_out ^ ACTIVE_LOW;
                end
            end
        end
    end

    for (genvar g = 0; g < NBITS; g++) begin : g_bit
        scan_debounce #(
            .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
        ) u_debounce (
            .clk        (clk),
            .rst        (rst),
            .i_update   (w_update),
            .i_sample   (r_sample[g]),
            .o_state    (buttons[g]),
            .o_pressed  (pressed[g]),
            .o_released (released[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_button_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_button_scanner
// Purpose  : Drives a 165-style chain model with directed and random button
//            patterns and compares against a per-scan debounce reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_scanner;

    localparam int NBITS          = 16;
    localparam int CLK_DIV        = 4;
    localparam int DEBOUNCE_SCANS = 4;
    localparam int c_PERIOD       = CLK_DIV * 2 * NBITS + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             shiftreg_clk;
    logic             shiftreg_loadn;
    logic             shiftreg_out;
    logic [NBITS-1:0] buttons;
    logic [NBITS-1:0] pressed;
    logic [NBITS-1:0] released;
    logic             scan_done;

    always #5 clk = ~clk;

    button_scanner #(
        .NBITS          (NBITS),
        .CLK_DIV        (CLK_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .shiftreg_clk   (shiftreg_clk),
        .shiftreg_loadn (shiftreg_loadn),
        .shiftreg_out   (shiftreg_out),
        .buttons        (buttons),
        .pressed        (pressed),
        .released       (released),
        .scan_done      (scan_done)
    );

    // Chain: raw lines are low where a button is pressed.
    logic [NBITS-1:0] raw_lines;
    logic [NBITS-1:0] chain;
    logic             sclk_q = 1'b0;

    always @(posedge clk) begin
        if (!shiftreg_loadn)
            chain <= raw_lines;
        else if (shiftreg_clk && !sclk_q)
            chain <= {chain[NBITS-2:0], 1'b1};
        sclk_q <= shiftreg_clk;
    end
    assign shiftreg_out = chain[NBITS-1];

    // Reference: per scan, a bit flips once it has disagreed for DEBOUNCE_SCANS scans in a row.
    logic [NBITS-1:0] m_btn;
    int               m_cnt [NBITS];

    task automatic model_reset();
        m_btn = '0;
        for (int i = 0; i < NBITS; i++) m_cnt[i] = 0;
    endtask

    task automatic model_scan(input logic [NBITS-1:0] pat,
                              output logic [NBITS-1:0] ep, output logic [NBITS-1:0] er);
        ep = '0;
        er = '0;
        for (int i = 0; i < NBITS; i++) begin
            if (pat[i] == m_btn[i]) begin
                m_cnt[i] = 0;
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] >= DEBOUNCE_SCANS) begin
                    m_btn[i] = pat[i];
                    m_cnt[i] = 0;
                    if (pat[i]) ep[i] = 1'b1;
                    else        er[i] = 1'b1;
                end
            end
        end
    endtask

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    int   cnt_cyc  = 0;
    int   cnt_rise = 0;
    int   cnt_low  = 0;
    logic prev_sclk = 1'b0;
    logic [NBITS-1:0] obs_p, obs_r, acc_p;

    task automatic tick();
        @(negedge clk);
        cnt_cyc++;
        if (shiftreg_clk && !prev_sclk) cnt_rise++;
        prev_sclk = shiftreg_clk;
        if (!shiftreg_loadn) cnt_low++;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * c_PERIOD; i++) begin
            tick();
            if (scan_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("scan_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_scan(input logic [NBITS-1:0] pat, input bit steady);
        bit ok;
        logic [NBITS-1:0] ep, er;
        wait_done(ok);
        model_scan(pat, ep, er);
        check("buttons", buttons, m_btn);
        check("pressed", pressed, ep);
        check("released", released, er);
        obs_p = pressed;
        obs_r = released;
        acc_p = acc_p | pressed;
        if (steady) begin
            check("scan_period", cnt_cyc, c_PERIOD);
            check("sclk_rises", cnt_rise, NBITS - 1);
            check("loadn_low", cnt_low, CLK_DIV);
        end
        cnt_cyc  = 0;
        cnt_rise = 0;
        cnt_low  = 0;
        tick();
        check("pulse_width", {pressed, released}, 32'd0);
    endtask

    task automatic do_scan(input logic [NBITS-1:0] pat, input bit steady);
        raw_lines = ~pat;
        finish_scan(pat, steady);
    endtask

    task automatic expect_load_soon(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (shiftreg_loadn === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, got, 1);
    endtask

    initial begin
        logic [NBITS-1:0] pat;
        int bad;
        bit ok;
        rst       = 1'b1;
        en        = 1'b0;
        raw_lines = '1;
        acc_p     = '0;
        model_reset();
        repeat (3) tick();
        check("rst_loadn", shiftreg_loadn, 1);
        check("rst_sclk", shiftreg_clk, 0);
        check("rst_buttons", buttons, 0);
        check("rst_done", scan_done, 0);
        rst = 1'b0;
        tick();
        en = 1'b1;

        for (int s = 0; s < DEBOUNCE_SCANS; s++) do_scan(16'hA5C3, s != 0);
        check("a5c3_pressed", obs_p, 16'hA5C3);
        for (int s = 0; s < DEBOUNCE_SCANS; s++) do_scan(16'h0000, 1'b1);
        check("a5c3_released", obs_r, 16'hA5C3);

        // Bit 3 held one scan short of the threshold, then released.
        acc_p = '0;
        for (int s = 0; s < DEBOUNCE_SCANS - 1; s++) do_scan(16'h0008, 1'b1);
        do_scan(16'h0000, 1'b1);
        check("bit3_short_no_press", acc_p, 0);
        check("bit3_short_state", buttons[3], 0);

        acc_p = '0;
        for (int s = 0; s < DEBOUNCE_SCANS - 1; s++) do_scan(16'h0008, 1'b1);
        check("bit3_no_early_press", acc_p, 0);
        do_scan(16'h0008, 1'b1);
        check("bit3_press", obs_p, 16'h0008);

        for (int s = 0; s < DEBOUNCE_SCANS; s++) do_scan(16'h0001, 1'b1);
        for (int s = 0; s < DEBOUNCE_SCANS; s++) do_scan(16'h8000, 1'b1);
        check("rel0_press15_same_cycle", {obs_p[15], obs_r[0]}, 2'b11);

        // Drop en mid-scan: the scan must complete, then the pins stay idle.
        raw_lines = ~16'h8001;
        repeat (30) tick();
        en = 1'b0;
        finish_scan(16'h8001, 1'b0);
        bad = 0;
        repeat (50) begin
            tick();
            if (shiftreg_loadn !== 1'b1 || shiftreg_clk !== 1'b0) bad++;
        end
        check("idle_pins_hold", bad, 0);
        raw_lines = ~16'h8001;
        en = 1'b1;
        expect_load_soon("reenable_load");
        finish_scan(16'h8001, 1'b0);

        // Asynchronous reset while the shift clock is high.
        raw_lines = ~16'h1234;
        ok = 1'b0;
        for (int i = 0; i < c_PERIOD; i++) begin
            tick();
            if (shiftreg_clk === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("found_sclk_high", ok, 1);
        rst = 1'b1;
        #1;
        check("midrst_loadn", shiftreg_loadn, 1);
        check("midrst_sclk", shiftreg_clk, 0);
        check("midrst_buttons", buttons, 0);
        check("midrst_events", {pressed, released}, 32'd0);
        model_reset();
        tick();
        rst = 1'b0;
        expect_load_soon("post_reset_load");
        finish_scan(16'h1234, 1'b0);

        pat = 16'h1234;
        for (int s = 0; s < 30; s++) begin
            pat = pat ^ NBITS'($urandom & $urandom & $urandom);
            do_scan(pat, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
